// File: rtl/adder_seq_if.sv
// adder_seq_if: operand/result bundle for the adder_seq sequencer.
//   master : drives din/enter/start/clear, observes the result and status lines
//   slave  : the sequencer itself
//   din     W-bit operand, sampled on enter
//   enter   push din into the operand buffer (1-cycle pulse)
//   start   sum the buffered operands (1-cycle pulse)
//   clear   abort, flush buffer, zero outputs (1-cycle pulse)
//   result  W-bit sum mod 2^W;  ovf  sticky carry out of bit W-1
//   done    1-cycle pulse, result/ovf valid
//   busy    summing;  count/full/empty  buffer occupancy
interface adder_seq_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  din;
    logic          enter;
    logic          start;
    logic          clear;
    logic [W-1:0]  result;
    logic          ovf;
    logic          done;
    logic          busy;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    modport master (
        output din, enter, start, clear,
        input  result, ovf, done, busy, count, full, empty
    );

    modport slave (
        input  din, enter, start, clear,
        output result, ovf, done, busy, count, full, empty
    );
endinterface

// File: rtl/adder_seq.sv
// adder_seq: sequencer for one shared W-bit adder.
// Operands are pushed into a DEPTH-entry ring buffer with enter; start walks them
// through the adder one per clock into an accumulator, then publishes the sum and
// a sticky overflow flag with a one-cycle done pulse.
//   i_clk  system clock (rising edge)
//   i_rst  synchronous reset, active-high
//   bus    adder_seq_if slave modport (operand, control pulses, result/status)
module adder_seq #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input logic        i_clk,
    input logic        i_rst,
    adder_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    // Keep pointers at least one bit wide so DEPTH=1 still elaborates.
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSum  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_buf [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_acc;
    logic          r_acc_c;
    logic [W-1:0]  r_result;
    logic          r_ovf;
    logic          r_done;

    logic          w_full;
    logic          w_push;
    logic [W:0]    w_sum;
    logic [PW-1:0] w_wr_ptr_inc;
    logic [PW-1:0] w_rd_ptr_inc;

    assign w_full = (r_count == CW'(DEPTH));
    // Push only from IDLE; start wins over a coincident enter.
    assign w_push = (r_state == StIdle) && !bus.clear && !bus.start && bus.enter && !w_full;
    assign w_sum  = {1'b0, r_acc} + {1'b0, r_buf[r_rd_ptr]};

    assign w_wr_ptr_inc = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_inc = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

    // Buffer storage is never cleared; only pointers and count are.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_buf[r_wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || bus.clear) begin
            r_state  <= StIdle;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_acc    <= '0;
            r_acc_c  <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // done trails the DONE state by one edge, giving start-to-done latency N+1.
            r_done <= (r_state == StDone);
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_acc   <= '0;
                        r_acc_c <= 1'b0;
                        if (r_count != '0) begin
                            r_state <= StSum;
                        end else begin
                            r_state  <= StDone;
                            r_result <= '0;
                            r_ovf    <= 1'b0;
                        end
                    end else if (w_push) begin
                        r_wr_ptr <= w_wr_ptr_inc;
                        r_count  <= r_count + CW'(1);
                    end
                end
                StSum: begin
                    if (r_count != '0) begin
                        r_acc    <= w_sum[W-1:0];
                        r_acc_c  <= r_acc_c | w_sum[W];
                        r_rd_ptr <= w_rd_ptr_inc;
                        r_count  <= r_count - CW'(1);
                        if (r_count == CW'(1)) begin
                            // result/ovf are published only on entry to DONE.
                            r_state  <= StDone;
                            r_result <= w_sum[W-1:0];
                            r_ovf    <= r_acc_c | w_sum[W];
                        end
                    end else begin
                        r_state  <= StDone;
                        r_result <= r_acc;
                        r_ovf    <= r_acc_c;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.ovf    = r_ovf;
    assign bus.done   = r_done;
    assign bus.busy   = (r_state == StSum);
    assign bus.count  = r_count;
    assign bus.full   = w_full;
    assign bus.empty  = (r_count == '0);
endmodule

// File: doc/adder_seq.md
Name: adder_seq

Overview:
- Sequencer for a single shared W-bit adder.
- Operands are pushed one at a time into a small buffer (one `enter` pulse each).
- A `start` pulse walks the buffered operands through the adder, one per clock, into an accumulator, then presents the sum with a sticky overflow flag.
- Sits behind the button synchronizers on the board top: `enter`/`start`/`clear` come from synchronized, edge-detected keys, `din` from switches, `result` drives LEDs.

Parameters:
- W, 8, operand and result width in bits.
- DEPTH, 4, operand buffer capacity (>=1).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- din  input  W  operand value, sampled on `enter`
- enter  input  1  single-cycle pulse: push `din` into buffer
- start  input  1  single-cycle pulse: begin summing buffered operands
- clear  input  1  single-cycle pulse: abort, flush buffer, zero outputs
- result  output  W  accumulated sum, mod 2^W
- ovf  output  1  sticky: any carry out of bit W-1 during current sum
- done  output  1  one-cycle pulse: `result`/`ovf` valid
- busy  output  1  high while state is SUM
- count  output  $clog2(DEPTH+1)  operands currently buffered
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; result=0, ovf=0, done=0, busy=0, count=0; full=0, empty=1.
  - Buffer pointers zeroed.
  - rst overrides every other input, including mid-SUM.
- States: IDLE, SUM, DONE. Binary-encoded; unreachable encodings return to IDLE.
- Input priority per edge: rst > clear > start > enter.
- IDLE:
  - `enter` && !full: write din at wr_ptr, wr_ptr+1 mod DEPTH, count+1.
  - `enter` && full: ignored; no state change.
  - `start`: acc=0, ovf=0, rd_ptr unchanged.
    - count>0: go to SUM.
    - count==0: go directly to DONE (result=0, ovf=0).
  - `start`+`enter` in the same cycle: start wins; that enter is dropped.
- SUM (busy=1):
  - Each edge: {c, acc} = acc + buf[rd_ptr] (W+1-bit add); ovf |= c; rd_ptr+1 mod DEPTH; count-1.
  - The edge that consumes the last operand (count 1 -> 0) moves to DONE.
  - `enter` and `start` are ignored in SUM.
  - Exactly N cycles in SUM for N buffered operands.
- DONE:
  - done=1 for exactly one cycle; result=acc; ovf as accumulated.
  - Next edge goes to IDLE.
  - `enter` in DONE is ignored. `start` in DONE is ignored.
- Latency: if `start` is sampled at edge k with N operands, `done` is high during the cycle after edge k+N+1. For N=0, `done` is high after edge k+1.
- result/ovf hold their value from DONE until the next `start` reaches DONE, `clear`, or `rst`.
  - `result` is updated only on entry to DONE, not while summing.
- clear (any state):
  - Next state IDLE; buffer flushed (count=0, pointers zeroed).
  - result=0, ovf=0, done=0.
  - Mid-SUM clear aborts with no `done` pulse.
- Pointer wrap: wr_ptr/rd_ptr wrap modulo DEPTH. Buffer contents are not cleared, only pointers and count.
- Width rule: result is the low W bits of the true sum. ovf=1 iff the true sum is >= 2^W.
  - Because ovf is sticky per partial sum, it equals "true sum >= 2^W" for unsigned operands.
- Outputs full/empty/busy/count are registered-state decodes, valid the cycle after the causing edge.

Test Plan:
- Basic two-operand sum (W=8): rst; enter 0x12; enter 0x34; start -> busy 2 cycles, then done pulse 1 cycle with result=0x46, ovf=0; result holds 0x46 after.
- Overflow (W=8): enter 0xF0, 0x20, 0x05; start -> done after 3 SUM cycles, result=0x15, ovf=1; second run with 0x01, 0x01 -> result=0x02, ovf=0 (sticky flag re-cleared at start).
- Full buffer and drop (DEPTH=4): enter 1,2,3,4 -> full=1, count=4; enter 9 -> ignored; start -> result=0x0A. Then enter 5 twice, start -> result=0x0A, confirming pointer wrap.
- Empty start: rst; start -> no busy, done next-next cycle with result=0, ovf=0. Simultaneous start+enter(0x07) in IDLE -> enter dropped, count stays 0.
- Abort: enter 0x10, 0x20, 0x30; start; clear on the 2nd SUM cycle -> no done pulse, state IDLE, count=0, empty=1, result=0, ovf=0. rst asserted mid-SUM in another run gives the same outcome.
- Ignored inputs while busy: during SUM pulse enter(0xFF) and start -> count is unaffected by enter, sum is unchanged, and exactly one done pulse occurs.
